operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Parametrised second pipeline stage: decodes source registers, reads the register file, resolves operands through a forwarding network, detects load-use hazards and registers a decoded bundle for execute.
- Sits between instruction fetch and execute.
- Replaces the fixed-width stall/jump-only read stage with a valid/ready handshake, bypass and an internal hazard interlock.

Parameters:
- DATA_WIDTH, 16, register/operand width.
- ADDR_WIDTH, 16, program counter width.
- GPR_COUNT, 8, number of general-purpose registers; GPR_BITS = clog2(GPR_COUNT).
- FWD_PORTS, 2, number of forwarding sources; index 0 is the youngest and has the highest priority.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  instruction/pc valid from fetch.
- in_ready  out  1  stage accepts the instruction this cycle.
- instruction  in  16  instruction word; field decoding uses the architecture.vh macros.
- pc  in  ADDR_WIDTH  pc of the instruction.
- flush  in  1  jump taken; kill the held bundle and the incoming instruction.
- rf_addr0, rf_addr1  out  GPR_BITS each  combinational register-file read addresses.
- rf_data0, rf_data1  in  DATA_WIDTH each  register-file read data, same cycle.
- fwd_valid  in  FWD_PORTS  forwarding source i writes a register.
- fwd_addr  in  FWD_PORTS*GPR_BITS  packed destination registers.
- fwd_data  in  FWD_PORTS*DATA_WIDTH  packed write data.
- ex_load_valid  in  1  execute holds a LOAD.
- ex_load_dest  in  GPR_BITS  destination of that LOAD.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts the bundle.
- opcode  out  OPCODE_SIZE  opcode.
- dest  out  GPR_BITS  destination register.
- op_a, op_b  out  DATA_WIDTH each  resolved source operands.
- imm  out  DATA_WIDTH  value, constant or offset.
- condition  out  CONDITION_SIZE  jump condition.
- out_pc  out  ADDR_WIDTH  pc of the bundle.

Behaviour:
- Source decode, combinational:
  - ARITHMETIC/LOGIC: src0 = [5:3], src1 = [2:0].
  - SHIFT: src0 = [8:6].
  - LOAD/STORE and JMP: src0 = [2:0].
  - JMPCOND: src0 = [8:6], src1 = [2:0].
  - JMPRCOND: src0 = [8:6].
  - Every other case: no source is used. The use0/use1 flags mark which sources are used.
  - rf_addrX is driven 0 when the source is unused (no latches).
- Destination:
  - [8:6] for ARITHMETIC/LOGIC/SHIFT.
  - [10:8] for LOAD/STORE/LOADC.
  - 0 otherwise.
- Immediate:
  - SHIFT [5:0] and LOADC [7:0] are zero-extended.
  - JMPR/JMPRCOND [5:0] is sign-extended to DATA_WIDTH.
  - 0 otherwise.
- Condition: [11:9] for conditional jumps, else 0.
- Operand resolve: for each used source, take the lowest index i with fwd_valid[i] and fwd_addr[i] == src; otherwise take rf_data. Unused operands are 0.
- Hazard: hazard = ex_load_valid && ((use0 && src0 == ex_load_dest) || (use1 && src1 == ex_load_dest)).
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Capture on in_valid && in_ready; the bundle is registered and out_valid = 1 on the next edge, so latency is 1 cycle.
  - Hold: out_valid && !out_ready keeps all outputs stable.
  - Drain: out_ready with no capture sets out_valid = 0 next cycle.
  - A hazard inserts a bubble: out_valid drops after drain; fetch holds the instruction.
- Flush: highest priority; next edge gives out_valid = 0 and no capture regardless of in_valid or hazard.
- Reset (async, low): out_valid = 0 and all data outputs = 0 (opcode 0 = NOP). Reset mid-hold discards the bundle.
- Simultaneous drain and capture: out_valid stays 1 with the new bundle; this gives full throughput.

Optional Feature:
- Macro OPERAND_BYPASS_EN.
- Defined: forwarding as described above.
- Undefined:
  - Operands always come from rf_data.
  - Any used source matching a valid fwd_addr[i] also raises hazard, turning bypass into an interlock.
  - fwd_data is ignored.

Test Plan:
- ADD dest=r2, src r3, r4; rf gives 5 and 7; out_ready = 1 -> next cycle out_valid = 1, op_a = 5, op_b = 7, dest = 2, out_pc = pc.
- Same ADD with fwd_valid = 2'b11, fwd_addr = {r3, r3}, fwd_data = {9, 11} -> op_a = 11 from port 0; with OPERAND_BYPASS_EN off -> in_ready = 0 until fwd_valid clears, then op_a = rf value.
- ex_load_valid = 1, ex_load_dest = r4, incoming ADD src1 = r4 -> in_ready = 0 and a one-cycle bubble (out_valid = 0); ADD captured the cycle the load clears.
- Bundle held with out_ready = 0 for 3 cycles -> outputs unchanged and in_ready = 0; then out_ready = 1 with in_valid = 1 -> back-to-back bundles.
- JMPRCOND with offset 6'b111110 -> imm = -2 sign-extended, condition = [11:9]; flush in the same cycle -> out_valid = 0 next cycle.
- Reset asserted while out_valid = 1 -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: decodes sources, reads the register file, resolves operands and registers a bundle for execute.
// Define OPERAND_BYPASS_EN to resolve operands from the forwarding network; otherwise a forwarding match interlocks.

package operand_fetch_pkg;

  localparam int OPCODE_SIZE    = 4;
  localparam int CONDITION_SIZE = 3;

  // Instruction layout: opcode in [15:12]; the remaining fields depend on the opcode class.
  typedef enum logic [OPCODE_SIZE-1:0] {
    OP_NOP      = 4'd0,
    OP_ADD      = 4'd1,
    OP_SUB      = 4'd2,
    OP_AND      = 4'd3,
    OP_OR       = 4'd4,
    OP_XOR      = 4'd5,
    OP_SHIFT    = 4'd6,
    OP_LOAD     = 4'd7,
    OP_STORE    = 4'd8,
    OP_LOADC    = 4'd9,
    OP_JMP      = 4'd10,
    OP_JMPR     = 4'd11,
    OP_JMPCOND  = 4'd12,
    OP_JMPRCOND = 4'd13,
    OP_HALT     = 4'd14,
    OP_RSVD     = 4'd15
  } opcode_t;

endpackage

module operand_fetch_stage
  import operand_fetch_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 16,
  parameter  int GPR_COUNT  = 8,
  parameter  int FWD_PORTS  = 2,
  localparam int GPR_BITS   = $clog2(GPR_COUNT)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [15:0]                     instruction,
  input  logic [ADDR_WIDTH-1:0]           pc,
  input  logic                            flush,
  output logic [GPR_BITS-1:0]             rf_addr0,
  output logic [GPR_BITS-1:0]             rf_addr1,
  input  logic [DATA_WIDTH-1:0]           rf_data0,
  input  logic [DATA_WIDTH-1:0]           rf_data1,
  input  logic [FWD_PORTS-1:0]            fwd_valid,
  input  logic [FWD_PORTS*GPR_BITS-1:0]   fwd_addr,
  input  logic [FWD_PORTS*DATA_WIDTH-1:0] fwd_data,
  input  logic                            ex_load_valid,
  input  logic [GPR_BITS-1:0]             ex_load_dest,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OPCODE_SIZE-1:0]          opcode,
  output logic [GPR_BITS-1:0]             dest,
  output logic [DATA_WIDTH-1:0]           op_a,
  output logic [DATA_WIDTH-1:0]           op_b,
  output logic [DATA_WIDTH-1:0]           imm,
  output logic [CONDITION_SIZE-1:0]       condition,
  output logic [ADDR_WIDTH-1:0]           out_pc
);

  typedef struct packed {
    logic [OPCODE_SIZE-1:0]    opcode;
    logic [GPR_BITS-1:0]       dest;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic [DATA_WIDTH-1:0]     imm;
    logic [CONDITION_SIZE-1:0] condition;
    logic [ADDR_WIDTH-1:0]     pc;
  } bundle_t;

  opcode_t                   op;
  logic [GPR_BITS-1:0]       src0;
  logic [GPR_BITS-1:0]       src1;
  logic                      use0;
  logic                      use1;
  logic [GPR_BITS-1:0]       dest_d;
  logic [DATA_WIDTH-1:0]     imm_d;
  logic [CONDITION_SIZE-1:0] cond_d;

  assign op = opcode_t'(instruction[15:12]);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    src0   = '0;
    src1   = '0;
    use0   = 1'b0;
    use1   = 1'b0;
    dest_d = '0;
    imm_d  = '0;
    cond_d = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        use0   = 1'b1;
        use1   = 1'b1;
        src0   = GPR_BITS'(instruction[5:3]);
        src1   = GPR_BITS'(instruction[2:0]);
        dest_d = GPR_BITS'(instruction[8:6]);
      end
      OP_SHIFT: begin
        use0   = 1'b1;
        src0   = GPR_BITS'(instruction[8:6]);
        dest_d = GPR_BITS'(instruction[8:6]);
        imm_d  = DATA_WIDTH'(instruction[5:0]);
      end
      OP_LOAD, OP_STORE: begin
        use0   = 1'b1;
        src0   = GPR_BITS'(instruction[2:0]);
        dest_d = GPR_BITS'(instruction[10:8]);
      end
      OP_LOADC: begin
        dest_d = GPR_BITS'(instruction[10:8]);
        imm_d  = DATA_WIDTH'(instruction[7:0]);
      end
      OP_JMP: begin
        use0 = 1'b1;
        src0 = GPR_BITS'(instruction[2:0]);
      end
      OP_JMPR: begin
        imm_d = DATA_WIDTH'($signed(instruction[5:0]));
      end
      OP_JMPCOND: begin
        use0   = 1'b1;
        use1   = 1'b1;
        src0   = GPR_BITS'(instruction[8:6]);
        src1   = GPR_BITS'(instruction[2:0]);
        cond_d = CONDITION_SIZE'(instruction[11:9]);
      end
      OP_JMPRCOND: begin
        use0   = 1'b1;
        src0   = GPR_BITS'(instruction[8:6]);
        imm_d  = DATA_WIDTH'($signed(instruction[5:0]));
        cond_d = CONDITION_SIZE'(instruction[11:9]);
      end
      default: ;
    endcase
  end

  assign rf_addr0 = src0;
  assign rf_addr1 = src1;

  // Forwarding match: iterate from the oldest port down so the youngest matching port wins.
  logic                  fwd_hit0;
  logic                  fwd_hit1;
  logic [DATA_WIDTH-1:0] fwd_val0;
  logic [DATA_WIDTH-1:0] fwd_val1;

  always_comb begin
    fwd_hit0 = 1'b0;
    fwd_hit1 = 1'b0;
    fwd_val0 = '0;
    fwd_val1 = '0;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_addr[i*GPR_BITS +: GPR_BITS] == src0) begin
        fwd_hit0 = 1'b1;
`ifdef OPERAND_BYPASS_EN
        fwd_val0 = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
      if (fwd_valid[i] && fwd_addr[i*GPR_BITS +: GPR_BITS] == src1) begin
        fwd_hit1 = 1'b1;
`ifdef OPERAND_BYPASS_EN
        fwd_val1 = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
    end
  end

  logic [DATA_WIDTH-1:0] op_a_d;
  logic [DATA_WIDTH-1:0] op_b_d;
  logic                  fwd_block;

`ifdef OPERAND_BYPASS_EN
  assign op_a_d    = use0 ? (fwd_hit0 ? fwd_val0 : rf_data0) : '0;
  assign op_b_d    = use1 ? (fwd_hit1 ? fwd_val1 : rf_data1) : '0;
  assign fwd_block = 1'b0;
`else
  // Without bypass a pending write to a source must land in the register file before the read.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_data, fwd_val0, fwd_val1};
  assign op_a_d     = use0 ? rf_data0 : '0;
  assign op_b_d     = use1 ? rf_data1 : '0;
  assign fwd_block  = (use0 && fwd_hit0) || (use1 && fwd_hit1);
`endif

  logic load_hazard;
  logic hazard;
  logic capture;

  assign load_hazard = ex_load_valid &&
                       ((use0 && src0 == ex_load_dest) || (use1 && src1 == ex_load_dest));
  assign hazard      = load_hazard || fwd_block;
  assign in_ready    = (!out_valid || out_ready) && !hazard && !flush;
  assign capture     = in_valid && in_ready;

  bundle_t bundle_d;
  bundle_t bundle_q;

  always_comb begin
    bundle_d           = '0;
    bundle_d.opcode    = instruction[15:12];
    bundle_d.dest      = dest_d;
    bundle_d.op_a      = op_a_d;
    bundle_d.op_b      = op_b_d;
    bundle_d.imm       = imm_d;
    bundle_d.condition = cond_d;
    bundle_d.pc        = pc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the bundle registers are reset too, so execute sees a NOP with zeroed fields after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      bundle_q  <= bundle_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign opcode    = bundle_q.opcode;
  assign dest      = bundle_q.dest;
  assign op_a      = bundle_q.op_a;
  assign op_b      = bundle_q.op_b;
  assign imm       = bundle_q.imm;
  assign condition = bundle_q.condition;
  assign out_pc    = bundle_q.pc;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed testbench for operand_fetch_stage: decode, forwarding/interlock, load-use bubble, handshake, flush, reset.
module tb_operand_fetch_stage;
  import operand_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic        flush;
  logic [2:0]  rf_addr0, rf_addr1;
  logic [15:0] rf_data0, rf_data1;
  logic [1:0]  fwd_valid;
  logic [5:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        ex_load_valid;
  logic [2:0]  ex_load_dest;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [15:0] op_a, op_b, imm;
  logic [2:0]  condition;
  logic [15:0] out_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  operand_fetch_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .flush(flush),
    .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_data0(rf_data0), .rf_data1(rf_data1),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .ex_load_valid(ex_load_valid), .ex_load_dest(ex_load_dest),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .dest(dest),
    .op_a(op_a), .op_b(op_b), .imm(imm), .condition(condition), .out_pc(out_pc)
  );

  function automatic logic [15:0] rrr(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] s0, input logic [2:0] s1);
    return {op, 3'b000, d, s0, s1};
  endfunction

  task automatic drive_idle();
    in_valid = 0; instruction = '0; pc = '0; flush = 0; rf_data0 = '0; rf_data1 = '0;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0; ex_load_valid = 0; ex_load_dest = '0; out_ready = 1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    drive_idle();
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    checks++; if ({opcode, dest, op_a, op_b, imm, condition, out_pc} !== '0) begin failures++; $display("FAIL reset_data got=%h/%h/%h/%h want=0", opcode, op_a, imm, out_pc); end
    reset = 1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_add();
    instruction = rrr(OP_ADD, 3'd2, 3'd3, 3'd4); pc = 16'h0100;
    rf_data0 = 16'd5; rf_data1 = 16'd7; in_valid = 1; #1;
    checks++; if ({rf_addr0, rf_addr1} !== {3'd3, 3'd4}) begin failures++; $display("FAIL add_rf_addr got=%0d,%0d want=3,4", rf_addr0, rf_addr1); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%0b want=1", in_ready); end
    step(); in_valid = 0; #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b want=1", out_valid); end
    checks++; if ({op_a, op_b} !== {16'd5, 16'd7}) begin failures++; $display("FAIL add_ops got=%0d,%0d want=5,7", op_a, op_b); end
    checks++; if ({opcode, dest, out_pc} !== {4'd1, 3'd2, 16'h0100}) begin failures++; $display("FAIL add_fields got=%0d,%0d,%h want=1,2,0100", opcode, dest, out_pc); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_forward();
    instruction = rrr(OP_ADD, 3'd2, 3'd3, 3'd4); pc = 16'h0200;
    rf_data0 = 16'd5; rf_data1 = 16'd7;
    fwd_valid = 2'b11; fwd_addr = {3'd3, 3'd3}; fwd_data = {16'd9, 16'd11}; in_valid = 1; #1;
`ifdef OPERAND_BYPASS_EN
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fwd_in_ready got=%0b want=1", in_ready); end
    step(); in_valid = 0; fwd_valid = '0; #1;
    checks++; if ({out_valid, op_a, op_b} !== {1'b1, 16'd11, 16'd7}) begin failures++; $display("FAIL fwd_prio got=%0b,%0d,%0d want=1,11,7", out_valid, op_a, op_b); end
`else
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fwd_interlock got=%0b want=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fwd_bubble got=%0b want=0", out_valid); end
    fwd_valid = '0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fwd_release got=%0b want=1", in_ready); end
    step(); in_valid = 0; #1;
    checks++; if ({out_valid, op_a, op_b} !== {1'b1, 16'd5, 16'd7}) begin failures++; $display("FAIL fwd_rf_ops got=%0b,%0d,%0d want=1,5,7", out_valid, op_a, op_b); end
`endif
    step();
    // Only port 1 matches (src1 = r4); port 0 names r0 but is not valid.
    fwd_valid = 2'b10; fwd_addr = {3'd4, 3'd0}; fwd_data = {16'd9, 16'd11}; in_valid = 1; #1;
`ifdef OPERAND_BYPASS_EN
    step(); in_valid = 0; fwd_valid = '0; #1;
    checks++; if ({op_a, op_b} !== {16'd5, 16'd9}) begin failures++; $display("FAIL fwd_port1 got=%0d,%0d want=5,9", op_a, op_b); end
`else
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fwd_port1_interlock got=%0b want=0", in_ready); end
    fwd_valid = '0;
    step(); in_valid = 0; #1;
    checks++; if ({op_a, op_b} !== {16'd5, 16'd7}) begin failures++; $display("FAIL fwd_port1_rf got=%0d,%0d want=5,7", op_a, op_b); end
`endif
    step();
  endtask

  task automatic test_load_use();
    instruction = rrr(OP_ADD, 3'd2, 3'd3, 3'd4); pc = 16'h0300;
    rf_data0 = 16'd5; rf_data1 = 16'd7;
    ex_load_valid = 1; ex_load_dest = 3'd4; in_valid = 1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL load_use_stall got=%0b want=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL load_use_bubble got=%0b want=0", out_valid); end
    ex_load_valid = 0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL load_use_release got=%0b want=1", in_ready); end
    step(); in_valid = 0; #1;
    checks++; if ({out_valid, op_b, out_pc} !== {1'b1, 16'd7, 16'h0300}) begin failures++; $display("FAIL load_use_capture got=%0b,%0d,%h want=1,7,0300", out_valid, op_b, out_pc); end
    step();
    // LOADC uses no source, so a load to r0 must not stall it.
    instruction = {4'(OP_LOADC), 1'b0, 3'd5, 8'hA5}; pc = 16'h0302;
    ex_load_valid = 1; ex_load_dest = 3'd0; in_valid = 1; #1;
    checks++; if ({in_ready, rf_addr0, rf_addr1} !== {1'b1, 3'd0, 3'd0}) begin failures++; $display("FAIL loadc_ready got=%0b,%0d,%0d want=1,0,0", in_ready, rf_addr0, rf_addr1); end
    step(); in_valid = 0; ex_load_valid = 0; #1;
    checks++; if ({dest, imm, op_a, op_b} !== {3'd5, 16'h00A5, 16'd0, 16'd0}) begin failures++; $display("FAIL loadc_fields got=%0d,%h,%h,%h want=5,00a5,0,0", dest, imm, op_a, op_b); end
    step();
  endtask

  task automatic test_shift();
    instruction = {4'(OP_SHIFT), 3'b000, 3'd6, 6'b101010}; pc = 16'h0400;
    rf_data0 = 16'h0F0F; rf_data1 = 16'h1111; in_valid = 1; #1;
    checks++; if ({rf_addr0, rf_addr1} !== {3'd6, 3'd0}) begin failures++; $display("FAIL shift_rf_addr got=%0d,%0d want=6,0", rf_addr0, rf_addr1); end
    step(); in_valid = 0; #1;
    checks++; if ({dest, imm, op_a, op_b} !== {3'd6, 16'd42, 16'h0F0F, 16'd0}) begin failures++; $display("FAIL shift_fields got=%0d,%h,%h,%h want=6,002a,0f0f,0", dest, imm, op_a, op_b); end
    step();
  endtask

  task automatic test_back_to_back();
    instruction = rrr(OP_ADD, 3'd2, 3'd3, 3'd4); pc = 16'h0010;
    rf_data0 = 16'd5; rf_data1 = 16'd7; in_valid = 1; out_ready = 1;
    step();
    instruction = rrr(OP_SUB, 3'd1, 3'd2, 3'd3); pc = 16'h0012;
    rf_data0 = 16'd20; rf_data1 = 16'd30; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({in_ready, out_valid, op_a, out_pc} !== {1'b0, 1'b1, 16'd5, 16'h0010}) begin failures++; $display("FAIL hold_%0d got=%0b,%0b,%0d,%h want=0,1,5,0010", k, in_ready, out_valid, op_a, out_pc); end
      step();
    end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%0b want=1", in_ready); end
    step();
    instruction = rrr(OP_XOR, 3'd7, 3'd1, 3'd2); pc = 16'h0014;
    rf_data0 = 16'd3; rf_data1 = 16'd4; #1;
    checks++; if ({out_valid, opcode, op_a, op_b, out_pc} !== {1'b1, 4'd2, 16'd20, 16'd30, 16'h0012}) begin failures++; $display("FAIL b2b_first got=%0b,%0d,%0d,%0d,%h want=1,2,20,30,0012", out_valid, opcode, op_a, op_b, out_pc); end
    step(); in_valid = 0; #1;
    checks++; if ({out_valid, opcode, dest, op_a, out_pc} !== {1'b1, 4'd5, 3'd7, 16'd3, 16'h0014}) begin failures++; $display("FAIL b2b_second got=%0b,%0d,%0d,%0d,%h want=1,5,7,3,0014", out_valid, opcode, dest, op_a, out_pc); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_jump_flush();
    instruction = {4'(OP_JMPRCOND), 3'b101, 3'd1, 6'b111110}; pc = 16'h0040;
    rf_data0 = 16'h1234; rf_data1 = 16'h5555; in_valid = 1; #1;
    checks++; if ({rf_addr0, rf_addr1} !== {3'd1, 3'd0}) begin failures++; $display("FAIL jmpr_rf_addr got=%0d,%0d want=1,0", rf_addr0, rf_addr1); end
    step(); in_valid = 0; #1;
    checks++; if ({imm, condition} !== {16'hFFFE, 3'd5}) begin failures++; $display("FAIL jmpr_imm_cond got=%h,%0d want=fffe,5", imm, condition); end
    checks++; if ({out_valid, op_a, op_b, dest} !== {1'b1, 16'h1234, 16'd0, 3'd0}) begin failures++; $display("FAIL jmpr_ops got=%0b,%h,%h,%0d want=1,1234,0,0", out_valid, op_a, op_b, dest); end
    in_valid = 1; flush = 1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b want=0", in_ready); end
    step(); flush = 0; in_valid = 0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_kill got=%0b want=0", out_valid); end
    in_valid = 1;
    step(); in_valid = 0; out_ready = 0; flush = 1;
    step(); flush = 0; out_ready = 1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_held got=%0b want=0", out_valid); end
  endtask

  task automatic test_async_reset();
    instruction = rrr(OP_ADD, 3'd2, 3'd3, 3'd4); pc = 16'h0080;
    rf_data0 = 16'd5; rf_data1 = 16'd7; in_valid = 1;
    step(); in_valid = 0; out_ready = 0; #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0b want=1", out_valid); end
    reset = 0; #1;
    checks++; if ({out_valid, opcode, dest, op_a, op_b, out_pc} !== '0) begin failures++; $display("FAIL areset_clear got=%0b,%0d,%0d,%h,%h,%h want=0", out_valid, opcode, dest, op_a, op_b, out_pc); end
    step(); reset = 1; out_ready = 1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_after got=%0b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_shift();
    test_back_to_back();
    test_jump_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
